keypad_entry_ctrl: RTL
======================

# keypad_entry_ctrl

Scans the 4x4 vending-machine keypad, debounces and decodes key presses, and assembles a two-digit item selection that it hands to the vending FSM over a valid/ready handshake. It owns the keypad column drive, so it replaces free-running column rotation with a controlled scan. It sits between the keypad pins and the vending FSM, and also supplies the partial-entry display value.

## Interface
- SCAN_MS, 4: clk_1ms cycles each column stays driven (range 2..255).
- DEBOUNCE, 3: consecutive identical scan frames needed to accept a press or a release (range 1..15).
- TIMEOUT_MS, 5000: idle cycles after which a partial entry is abandoned (range 1..65535).
- clk_1ms  in  1  system clock, 1 kHz, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- row  in  4  keypad rows, active-low.
- col  out  4  keypad column drive, active-low, one-hot-zero.
- sel_code  out  8  BCD selection: {tens, units}.
- sel_valid  out  1  selection offered to the vending FSM.
- sel_ready  in  1  vending FSM accepts the selection.
- entry  out  8  BCD digits entered so far, for the display.
- digit_cnt  out  2  number of digits entered (0..2).
- cancel_pulse  out  1  one-cycle pulse when an entry is cleared or times out.
- err_pulse  out  1  one-cycle pulse when a key is rejected.

## Operation
- Scan: col rotates 0111 → 1011 → 1101 → 1110 → 0111. Each column is held for SCAN_MS cycles. row is sampled on the last cycle of each dwell. One frame is four columns.
- Key map (col, row → key):
  - col 0111: rows 0111/1011/1101/1110 → D/C/B/A.
  - col 1011: → E/9/6/3.
  - col 1101: → F/8/5/2.
  - col 1110: → 0/7/4/1.
- Frame result:
  - Exactly one low row bit in the whole frame → that key.
  - No low bits → NONE.
  - More than one low bit (one or several columns) → MULTI, treated as NONE for press acceptance but does not count toward release.
- Debounce:
  - A key event fires once when the same key is seen in DEBOUNCE consecutive frames while the released flag is set. The event then clears released.
  - released sets after DEBOUNCE consecutive NONE frames.
  - A held key yields exactly one event.
- Entry FSM states: IDLE (0 digits), ONE, TWO, HOLD.
  - Digit 0-9: IDLE→ONE or ONE→TWO, shifted into entry (first digit becomes tens). A digit in TWO is ignored and pulses err_pulse.
  - A (enter): in TWO with entry≠00 → HOLD, with sel_code=entry and sel_valid=1. In TWO with 00, in ONE, or in IDLE → err_pulse, state unchanged.
  - C (clear): ONE/TWO → IDLE, entry=00, cancel_pulse. In IDLE, no effect and no pulse.
  - B, D, E, F: ignored, no pulse.
  - HOLD: all key events are ignored. On sel_valid&&sel_ready → IDLE, entry=00, digit_cnt=0.
- Timeout: a counter runs in ONE/TWO and restarts on every key event. When it reaches TIMEOUT_MS → IDLE, entry=00, cancel_pulse. The counter is frozen and cleared in IDLE and HOLD.

## Timing
- Reset values:
  - col=0111, scan counter=0, frame result=NONE, released=1, debounce count=0.
  - State IDLE, entry=00, digit_cnt=0, sel_code=00, sel_valid=0, cancel_pulse=0, err_pulse=0.
- Reset is asynchronous and takes effect immediately mid-scan or mid-handshake; any offered selection is dropped.
- Key event latency:
  - The event is registered on the cycle after the last sample of the accepting frame.
  - FSM outputs (entry, digit_cnt, sel_valid, pulses) update on the cycle after the event.
  - Minimum press-to-event time is DEBOUNCE×4×SCAN_MS cycles.
- Handshake:
  - sel_code is stable while sel_valid=1.
  - Transfer happens on the rising edge where both sel_valid and sel_ready are high; sel_valid is 0 the next cycle.
  - sel_ready while sel_valid=0 has no effect.
  - There is no combinational path from sel_ready to sel_valid.
- Simultaneous key event and timeout expiry in the same cycle: the key event wins and the timer restarts.
- Both pulses are exactly one cycle wide and never both high in the same cycle.
- Timer and counters saturate or wrap only as specified; the timeout counter is at least 16 bits.

## Test plan
- Reset, then row=1111 for 10 frames → col cycles 0111,1011,1101,1110 every 4 cycles; sel_valid=0; no pulses.
- Press 4 (col 1110/row 1101) for 3 frames, release, press 2, release, press A; sel_ready=1 → entry=42, digit_cnt=2; sel_valid high with sel_code=8'h42 for one cycle; then IDLE.
- Hold 7 for 50 frames → exactly one event (entry=07, digit_cnt=1). A bounce of 1 frame NONE inside the hold produces no second event.
- Enter 5 then A → err_pulse, state ONE. Then C → cancel_pulse, entry=00. Then 0,0,A → err_pulse.
- Enter 3, then idle 5000 cycles → cancel_pulse at expiry, digit_cnt=0. In a separate run, a key event landing on the expiry cycle keeps the entry.
- In HOLD with sel_ready=0 for 1000 cycles, press 9 and C → sel_valid stays high, sel_code unchanged. Assert rst_n=0 mid-hold → sel_valid=0 and col=0111 immediately.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// Selection handshake between the keypad entry controller and the vending FSM.
// The master offers a BCD selection with sel_valid and holds sel_code until sel_ready.
interface keypad_entry_ctrl_if;
  logic [7:0] sel_code;
  logic       sel_valid;
  logic       sel_ready;

  modport master (output sel_code, output sel_valid, input sel_ready);
  modport slave  (input sel_code, input sel_valid, output sel_ready);
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Scans and debounces the 4x4 keypad, then assembles a two-digit BCD selection
// that is offered to the vending FSM over a valid/ready handshake.
module keypad_entry_ctrl #(
  parameter int SCAN_MS    = 4,
  parameter int DEBOUNCE   = 3,
  parameter int TIMEOUT_MS = 5000
) (
  input  logic                       clk_1ms,
  input  logic                       rst_n,
  input  logic [3:0]                 row,
  output logic [3:0]                 col,
  keypad_entry_ctrl_if.master        sel,
  output logic [7:0]                 entry,
  output logic [1:0]                 digit_cnt,
  output logic                       cancel_pulse,
  output logic                       err_pulse
);

  typedef enum logic [1:0] {FRAME_NONE, FRAME_KEY, FRAME_MULTI} frame_t;
  typedef enum logic [1:0] {IDLE, ONE, TWO, HOLD} state_t;

  localparam logic [7:0]  SCAN_LAST  = 8'(SCAN_MS - 1);
  localparam logic [3:0]  DEB        = 4'(DEBOUNCE);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_MS - 1);
  localparam logic [3:0]  KEY_A      = 4'hA;
  localparam logic [3:0]  KEY_C      = 4'hC;

  logic [7:0]  scan_cnt;
  logic [1:0]  col_idx;
  logic        sample, frame_end;
  logic [1:0]  acc_cnt, tot_cnt;
  logic [3:0]  acc_key, cur_key, tot_key;
  logic [2:0]  cur_cnt;
  logic [3:0]  cnt_sum;
  frame_t      frame_res;

  logic [3:0]  last_key, key_cnt, none_cnt, key_cnt_next, none_cnt_next;
  logic        released, key_event;
  logic [3:0]  event_key;
  logic        ev_digit;

  state_t      state_q, state_d;
  logic [7:0]  entry_q, entry_d, sel_code_q, sel_code_d;
  logic [15:0] timer_q, timer_d;
  logic        cancel_q, cancel_d, err_q, err_d;

  function automatic logic [3:0] decode_key(input logic [1:0] idx, input logic [3:0] r);
    logic [1:0] rsel;
    logic [3:0] k;
    if (!r[3])      rsel = 2'd3;
    else if (!r[2]) rsel = 2'd2;
    else if (!r[1]) rsel = 2'd1;
    else            rsel = 2'd0;
    case ({idx, rsel})
      4'b00_11: k = 4'hD;  4'b00_10: k = 4'hC;  4'b00_01: k = 4'hB;  4'b00_00: k = 4'hA;
      4'b01_11: k = 4'hE;  4'b01_10: k = 4'h9;  4'b01_01: k = 4'h6;  4'b01_00: k = 4'h3;
      4'b10_11: k = 4'hF;  4'b10_10: k = 4'h8;  4'b10_01: k = 4'h5;  4'b10_00: k = 4'h2;
      4'b11_11: k = 4'h0;  4'b11_10: k = 4'h7;  4'b11_01: k = 4'h4;  default:  k = 4'h1;
    endcase
    return k;
  endfunction

  assign sample    = (scan_cnt == SCAN_LAST);
  assign frame_end = sample && (col_idx == 2'd3);
  assign col       = ~(4'b1000 >> col_idx);

  // A frame is one key only if exactly one row bit was low across all four columns.
  always_comb begin
    cur_cnt   = {2'b00, ~row[0]} + {2'b00, ~row[1]} + {2'b00, ~row[2]} + {2'b00, ~row[3]};
    cur_key   = decode_key(col_idx, row);
    cnt_sum   = {2'b00, acc_cnt} + {1'b0, cur_cnt};
    tot_cnt   = (cnt_sum >= 4'd2) ? 2'd2 : cnt_sum[1:0];
    tot_key   = (cur_cnt == 3'd1) ? cur_key : acc_key;
    frame_res = (tot_cnt == 2'd0) ? FRAME_NONE : (tot_cnt == 2'd1) ? FRAME_KEY : FRAME_MULTI;
    key_cnt_next  = 4'd1;
    if (tot_key == last_key && key_cnt != 4'd0)
      key_cnt_next = (key_cnt == 4'hF) ? 4'hF : key_cnt + 4'd1;
    none_cnt_next = (none_cnt == 4'hF) ? 4'hF : none_cnt + 4'd1;
  end

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      col_idx  <= '0;
      acc_cnt  <= '0;
      acc_key  <= '0;
    end else if (sample) begin
      scan_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
      acc_cnt  <= frame_end ? 2'd0 : tot_cnt;
      acc_key  <= frame_end ? 4'd0 : tot_key;
    end else begin
      scan_cnt <= scan_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      last_key  <= '0;
      key_cnt   <= '0;
      none_cnt  <= '0;
      released  <= 1'b1;
      key_event <= 1'b0;
      event_key <= '0;
    end else begin
      key_event <= 1'b0;
      if (frame_end) begin
        case (frame_res)
          FRAME_NONE: begin
            key_cnt  <= '0;
            none_cnt <= none_cnt_next;
            if (none_cnt_next >= DEB) released <= 1'b1;
          end
          FRAME_KEY: begin
            none_cnt <= '0;
            key_cnt  <= key_cnt_next;
            last_key <= tot_key;
            if (released && key_cnt_next >= DEB) begin
              key_event <= 1'b1;
              event_key <= tot_key;
              released  <= 1'b0;
            end
          end
          default: begin
            key_cnt  <= '0;
            none_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign ev_digit = (event_key <= 4'd9);

  // A key event always takes priority over timeout expiry and restarts the timer.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    sel_code_d = sel_code_q;
    timer_d    = timer_q;
    cancel_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (key_event) begin
          if (ev_digit) begin
            entry_d = {4'h0, event_key};
            state_d = ONE;
          end else if (event_key == KEY_A) begin
            err_d = 1'b1;
          end
        end
      end
      ONE, TWO: begin
        timer_d = timer_q + 16'd1;
        if (key_event) begin
          timer_d = '0;
          if (ev_digit) begin
            if (state_q == ONE) begin
              entry_d = {entry_q[3:0], event_key};
              state_d = TWO;
            end else begin
              err_d = 1'b1;
            end
          end else if (event_key == KEY_A) begin
            if (state_q == TWO && entry_q != 8'h00) begin
              state_d    = HOLD;
              sel_code_d = entry_q;
            end else begin
              err_d = 1'b1;
            end
          end else if (event_key == KEY_C) begin
            state_d  = IDLE;
            entry_d  = 8'h00;
            cancel_d = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d  = IDLE;
          entry_d  = 8'h00;
          timer_d  = '0;
          cancel_d = 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        if (sel.sel_ready) begin
          state_d = IDLE;
          entry_d = 8'h00;
        end
      end
    endcase
  end

  always_ff @(posedge clk_1ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      entry_q    <= '0;
      sel_code_q <= '0;
      timer_q    <= '0;
      cancel_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      sel_code_q <= sel_code_d;
      timer_q    <= timer_d;
      cancel_q   <= cancel_d;
      err_q      <= err_d;
    end
  end

  assign sel.sel_valid = (state_q == HOLD);
  assign sel.sel_code  = sel_code_q;
  assign entry         = entry_q;
  assign cancel_pulse  = cancel_q;
  assign err_pulse     = err_q;
  assign digit_cnt     = (state_q == IDLE) ? 2'd0 : (state_q == ONE) ? 2'd1 : 2'd2;

endmodule
